// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-file sequencer states and default widths.
package cpu_pkg;

    // Register-file sequencer states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } regfile_state_t;

    // Default datapath register width.
    localparam int unsigned CPU_DATA_W = 8;

endpackage

// File: rtl/cpu_regfile_clr_seq.sv
// Clear sequencer for the CPU register file: walks a pointer over every entry
// after reset or on request, and reports when the file is usable.
module cpu_regfile_clr_seq
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    regfile_state_t    state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;

    // State and clear-pointer registers; reset restarts the clear from entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // Next state: step through entries while clearing, re-enter clear on request.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            CLEAR: begin
                if (ptr == LAST) begin
                    state_nx = READY;
                    ptr_nx   = '0;
                end else begin
                    ptr_nx = ptr + ADDR_W'(1);
                end
            end
            READY: begin
                if (clr) begin
                    state_nx = CLEAR;
                    ptr_nx   = '0;
                end
            end
            default: begin
                state_nx = CLEAR;
                ptr_nx   = '0;
            end
        endcase
    end

    // ready and the clear-write port come straight from registers.
    assign ready    = (state == READY);
    assign clr_we   = (state == CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/cpu_regfile.sv
// CPU register file: one write port, two registered read ports with write-first
// bypass, optional hard-wired zero register, and a built-in clear sequencer.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = CPU_DATA_W,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_nx_a, rd_nx_b;

    // An address names a real, writable entry: in range and not the zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(DEPTH)) && !(ZERO_REG && (a == '0));
    endfunction

    cpu_regfile_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // While clearing, or on the edge a clear is accepted, writes drop and reads return 0.
    always_comb begin
        busy    = !ready || clr;
        wr_ok   = wr_en && !busy && addr_ok(wr_addr);
        rd_nx_a = '0;
        rd_nx_b = '0;
        if (!busy && addr_ok(rd_addr_a)) begin
            rd_nx_a = (wr_ok && (wr_addr == rd_addr_a)) ? wr_data : mem[rd_addr_a];
        end
        if (!busy && addr_ok(rd_addr_b)) begin
            rd_nx_b = (wr_ok && (wr_addr == rd_addr_b)) ? wr_data : mem[rd_addr_b];
        end
    end

    // Storage array: the sequencer's clear write or the accepted user write; no reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read ports load only when enabled and hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (rd_en_a) rd_data_a <= rd_nx_a;
            if (rd_en_b) rd_data_b <= rd_nx_b;
        end
    end

endmodule

// File: tb/tb_cpu_regfile.sv
// Scoreboard bench for cpu_regfile: a DEPTH=8 instance and a DEPTH=6 ZERO_REG instance.
module tb_cpu_regfile;

    logic clk = 1'b0;
    logic rst;

    logic       clr0, wr_en0, rd_en_a0, rd_en_b0, ready0;
    logic [2:0] wr_addr0, rd_addr_a0, rd_addr_b0;
    logic [7:0] wr_data0, rd_data_a0, rd_data_b0;

    logic       clr1, wr_en1, rd_en_a1, rd_en_b1, ready1;
    logic [2:0] wr_addr1, rd_addr_a1, rd_addr_b1;
    logic [7:0] wr_data1, rd_data_a1, rd_data_b1;

    typedef struct {
        int unsigned cyc;
        int unsigned sel;
        logic [7:0]  exp;
    } sb_item_t;

    sb_item_t    sb[$];
    int unsigned cyc_cnt = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    cpu_regfile #(.DATA_W(8), .DEPTH(8), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr0), .ready(ready0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_en_a(rd_en_a0), .rd_addr_a(rd_addr_a0), .rd_data_a(rd_data_a0),
        .rd_en_b(rd_en_b0), .rd_addr_b(rd_addr_b0), .rd_data_b(rd_data_b0)
    );

    cpu_regfile #(.DATA_W(8), .DEPTH(6), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .ready(ready1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_en_a(rd_en_a1), .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1),
        .rd_en_b(rd_en_b1), .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1)
    );

    function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] observe(input int unsigned sel);
        case (sel)
            0: return rd_data_a0;
            1: return rd_data_b0;
            2: return {7'b0, ready0};
            3: return rd_data_a1;
            4: return rd_data_b1;
            default: return {7'b0, ready1};
        endcase
    endfunction

    function automatic string sel_name(input int unsigned sel);
        case (sel)
            0: return "d0_rd_a";
            1: return "d0_rd_b";
            2: return "d0_ready";
            3: return "d1_rd_a";
            4: return "d1_rd_b";
            default: return "d1_ready";
        endcase
    endfunction

    // Monitor: after each edge, pop every expectation due on that edge and compare.
    always @(posedge clk) begin
        sb_item_t it;
        cyc_cnt++;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            it = sb.pop_front();
            chk($sformatf("%s@%0d", sel_name(it.sel), it.cyc), observe(it.sel), it.exp);
        end
    end

    // Expectation for the coming edge.
    task automatic expect_next(input int unsigned sel, input logic [7:0] exp);
        sb.push_back('{cyc: cyc_cnt + 1, sel: sel, exp: exp});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle0();
        clr0 = 1'b0; wr_en0 = 1'b0; rd_en_a0 = 1'b0; rd_en_b0 = 1'b0;
    endtask

    task automatic idle1();
        clr1 = 1'b0; wr_en1 = 1'b0; rd_en_a1 = 1'b0; rd_en_b1 = 1'b0;
    endtask

    task automatic wr0(input logic [2:0] a, input logic [7:0] d);
        wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d;
    endtask

    task automatic wr1(input logic [2:0] a, input logic [7:0] d);
        wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
    endtask

    task automatic rda0(input logic [2:0] a, input logic [7:0] exp);
        rd_en_a0 = 1'b1; rd_addr_a0 = a; expect_next(0, exp);
    endtask

    task automatic rdb0(input logic [2:0] a, input logic [7:0] exp);
        rd_en_b0 = 1'b1; rd_addr_b0 = a; expect_next(1, exp);
    endtask

    task automatic rda1(input logic [2:0] a, input logic [7:0] exp);
        rd_en_a1 = 1'b1; rd_addr_a1 = a; expect_next(3, exp);
    endtask

    task automatic rdb1(input logic [2:0] a, input logic [7:0] exp);
        rd_en_b1 = 1'b1; rd_addr_b1 = a; expect_next(4, exp);
    endtask

    function automatic logic [7:0] fillv(input int unsigned i);
        return 8'(8'h81 + 8'(i) * 8'h11);
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst = 1'b0;
        wr_addr0 = '0; wr_data0 = '0; rd_addr_a0 = '0; rd_addr_b0 = '0;
        wr_addr1 = '0; wr_data1 = '0; rd_addr_a1 = '0; rd_addr_b1 = '0;
        idle0(); idle1();
        repeat (2) @(negedge clk);
        chk("rst_d0_ready", {7'b0, ready0}, 8'h00);
        chk("rst_d0_rd_a", rd_data_a0, 8'h00);
        chk("rst_d0_rd_b", rd_data_b0, 8'h00);
        chk("rst_d1_ready", {7'b0, ready1}, 8'h00);
        rst = 1'b1;

        // Initial clear: ready after exactly DEPTH edges; a read during clear gives 0.
        for (int i = 1; i <= 8; i++) begin
            expect_next(2, (i >= 8) ? 8'h01 : 8'h00);
            expect_next(5, (i >= 6) ? 8'h01 : 8'h00);
            if (i == 1) rda0(3'd3, 8'h00);
            step(); idle0();
        end

        rda0(3'd3, 8'h00); rdb0(3'd7, 8'h00); step(); idle0();

        // Write then read on the next cycle; both ports on the same address.
        wr0(3'd2, 8'hA5); step(); idle0();
        rda0(3'd2, 8'hA5); rdb0(3'd2, 8'hA5); step(); idle0();

        // Same-edge bypass on both ports.
        wr0(3'd5, 8'h3C); rda0(3'd5, 8'h3C); rdb0(3'd5, 8'h3C); step(); idle0();

        // Without enables the outputs hold.
        rd_addr_a0 = 3'd2; rd_addr_b0 = 3'd2;
        expect_next(0, 8'h3C); expect_next(1, 8'h3C); step();

        // Fill every entry and read it back.
        for (int unsigned i = 0; i < 8; i++) begin
            wr0(3'(i), fillv(i)); step(); idle0();
        end
        for (int unsigned i = 0; i < 4; i++) begin
            rda0(3'(i), fillv(i)); rdb0(3'(i + 4), fillv(i + 4)); step(); idle0();
        end

        // clr beats a same-edge write; reads on that edge give 0; ready low for 8 edges.
        clr0 = 1'b1; wr0(3'd1, 8'h77); rda0(3'd1, 8'h00); rdb0(3'd1, 8'h00);
        expect_next(2, 8'h00); step(); idle0();
        for (int i = 1; i <= 8; i++) begin
            expect_next(2, (i == 8) ? 8'h01 : 8'h00);
            if (i == 2) rda0(3'd0, 8'h00);
            if (i == 5) wr0(3'd0, 8'h99);
            step(); idle0();
        end
        for (int unsigned i = 0; i < 4; i++) begin
            rda0(3'(i), 8'h00); rdb0(3'(i + 4), 8'h00); step(); idle0();
        end
        wr0(3'd7, 8'h5C); step(); idle0();
        rda0(3'd7, 8'h5C); step(); idle0();

        // DEPTH=6, ZERO_REG=1 instance.
        wr1(3'd0, 8'hFF); rda1(3'd0, 8'h00); step(); idle1();
        rda1(3'd0, 8'h00); rdb1(3'd0, 8'h00); step(); idle1();
        wr1(3'd1, 8'h5A); step(); idle1();
        wr1(3'd7, 8'hEE); rda1(3'd7, 8'h00); rdb1(3'd1, 8'h5A); step(); idle1();
        wr1(3'd6, 8'hC3); step(); idle1();
        rda1(3'd7, 8'h00); rdb1(3'd6, 8'h00); step(); idle1();
        wr1(3'd5, 8'h21); step(); idle1();
        rda1(3'd5, 8'h21); rdb1(3'd1, 8'h5A); step(); idle1();

        // Reset asserted with non-zero outputs: everything drops at once.
        wr0(3'd4, 8'h42); rda0(3'd4, 8'h42); step(); idle0();
        rst = 1'b0;
        #1;
        chk("arst_d0_rd_a", rd_data_a0, 8'h00);
        chk("arst_d0_ready", {7'b0, ready0}, 8'h00);
        chk("arst_d1_rd_a", rd_data_a1, 8'h00);
        chk("arst_d1_rd_b", rd_data_b1, 8'h00);
        chk("arst_d1_ready", {7'b0, ready1}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            expect_next(2, 8'h00); expect_next(5, 8'h00); step();
        end

        // Reset again at clear step 4: a full DEPTH-edge clear follows release.
        rst = 1'b0;
        #1;
        chk("arst2_d0_ready", {7'b0, ready0}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            expect_next(2, (i >= 8) ? 8'h01 : 8'h00);
            expect_next(5, (i >= 6) ? 8'h01 : 8'h00);
            step();
        end

        // Reset during a pending write.
        wr0(3'd6, 8'h66); rda0(3'd6, 8'h66); step(); idle0();
        wr0(3'd6, 8'h11); rd_en_a0 = 1'b1; rd_addr_a0 = 3'd6;
        rst = 1'b0;
        #1;
        chk("arst3_d0_rd_a", rd_data_a0, 8'h00);
        chk("arst3_d0_ready", {7'b0, ready0}, 8'h00);
        @(negedge clk);
        idle0();
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            expect_next(2, (i >= 8) ? 8'h01 : 8'h00); step();
        end
        rda0(3'd6, 8'h00); rdb0(3'd4, 8'h00); step(); idle0();

        repeat (3) step();
        chk("sb_drain", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_regfile.md
# cpu_regfile

Parametrised CPU register file, DATA_W bits by DEPTH entries, with one write port and two independent registered read ports (A and B). It replaces the single-port 4-bit register store in the CPU datapath. Write-first bypass lets the decode stage read a result in the same cycle it is written back. A built-in clear sequencer zeroes every entry after reset or on request, and flags completion with `ready`.

## Interface
- `DATA_W`, default 8: width of each register.
- `DEPTH`, default 8: number of registers; must be at least 2; need not be a power of two.
- `ADDR_W`, default $clog2(DEPTH): address width; derived, do not override.
- `ZERO_REG`, default 0: if 1, entry 0 always reads 0 and ignores writes.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  request a full clear; accepted only while `ready`=1.
- `ready`  out  1  1 when the file is initialised and accepting writes.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_en_a`  in  1  read strobe, port A.
- `rd_addr_a`  in  ADDR_W  read address, port A.
- `rd_data_a`  out  DATA_W  registered read data, port A.
- `rd_en_b`, `rd_addr_b`, `rd_data_b`: same as port A, for port B.

## Operation
- FSM states: CLEAR and READY.
- Reset (`rst`=0, asynchronous):
  - state goes to CLEAR, clear pointer to 0;
  - `ready`=0, `rd_data_a`=0, `rd_data_b`=0;
  - the storage array itself is not reset asynchronously.
- CLEAR state:
  - each edge writes 0 to entry [ptr] and increments ptr;
  - on the edge that clears entry DEPTH-1, state goes to READY and `ready` goes to 1;
  - `wr_en` and `clr` are ignored;
  - a read with `rd_en`=1 loads 0 into its port's output.
- READY state, `clr`=1: state goes to CLEAR, ptr to 0, `ready` to 0 on that edge.
  - `clr` has priority over `wr_en`; that write is dropped.
  - Reads on that edge load 0.
- READY state, `wr_en`=1 and `wr_addr` < DEPTH: the entry is written on the edge.
  - Writes to an address ≥ DEPTH are dropped.
  - With ZERO_REG=1, writes to entry 0 are dropped.
- Read, `rd_en_x`=1:
  - `rd_data_x` loads the entry's value on the edge;
  - an address ≥ DEPTH, or entry 0 with ZERO_REG=1, loads 0;
  - with `rd_en_x`=0, `rd_data_x` holds its previous value.
- Bypass: on a read of the address being written on the same edge (accepted write), `rd_data_x` loads `wr_data`. Both ports may bypass at once.
- Ports A and B may read the same address simultaneously; both return the same value.

## Timing
- Read latency is 1 cycle: address and enable are sampled at edge N; data is valid after edge N and stable until the next enabled read.
- Write latency is 1 cycle: a write at edge N is visible to a non-bypassed read at edge N+1, and to a bypassed read at edge N itself.
- Clear duration is exactly DEPTH edges:
  - after `rst` release, edges 1..DEPTH clear entries 0..DEPTH-1;
  - `ready`=1 after edge DEPTH;
  - the first write is accepted on edge DEPTH+1.
- Reset asserted mid-clear or mid-operation immediately restarts from CLEAR with ptr=0; there are no partial-state leftovers visible on outputs.
- `ready` is a registered output with no combinational paths from inputs. `rd_data_x` are registered outputs.

## Structure
- Shared package `cpu_pkg`:
  - enum `regfile_state_t` (CLEAR, READY);
  - default width constant `CPU_DATA_W`=8.
- One natural sub-module, `cpu_regfile_clr_seq`: holds the FSM, clear pointer, `ready`, and the clear-write strobe/address. The top level muxes its write port onto the array.
- The array is an unpacked reg array of DEPTH entries with no reset on the storage.

## Test plan
- Reset then idle, DEPTH=8: `ready` rises after exactly 8 edges. Reading A=3, B=7 returns 0 and 0.
- Write 0xA5 to r2, then read A=2 next cycle: `rd_data_a`=0xA5 one cycle after the read strobe.
- Same-edge write 0x3C to r5 with reads A=5, B=5: both ports = 0x3C after that edge (bypass).
- Fill all entries, assert `clr` for one cycle together with a write to r1:
  - the write is dropped and `ready` drops for 8 edges;
  - all entries then read 0.
- ZERO_REG=1, write 0xFF to r0: reads of r0 return 0. With DEPTH=6, a write to address 7 is dropped and a read of address 7 returns 0.
- `rst` pulsed low at clear step 4, and again mid-write: outputs go to 0 immediately, and `ready` returns after exactly DEPTH edges from release.
